// File: rtl/seg_display_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg_pkg
//  Description : Shared segment encodings, conversion FSM state type and
//                small constant helpers for the seven-segment scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_DIGIT [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } conv_state_t;

    // Largest decimal value representable in n digits (10^n - 1)
    function automatic longint unsigned dec_max(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_display_scan_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble converter. start_i loads a value
//                and clears the BCD accumulator; one add-3/shift step runs per
//                cycle for DATA_WIDTH cycles. done_o flags the final step, so
//                bcd_o holds the finished result on the following cycle.
//                The accumulator keeps only NUM_DIGITS digits, so the result
//                is the value modulo 10^NUM_DIGITS.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [BCD_W-1:0]      bcd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [BCD_W-1:0]      bcd_adj;

    // Add 3 to every nibble of 5 or more ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, otherwise step while steps remain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else if (start_i) begin
            shift_q <= data_i;
            bcd_q   <= '0;
            cnt_q   <= CNT_W'(DATA_WIDTH);
        end else if (cnt_q != '0) begin
            bcd_q   <= {bcd_adj[BCD_W-2:0], shift_q[DATA_WIDTH-1]};
            shift_q <= shift_q << 1;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg_display_scan
//  Description : Multi-digit seven-segment controller. Selects a register by
//                SW, converts it continuously to decimal or hex, stores a
//                blanked/overflow-aware segment buffer and time-multiplexes
//                it across NUM_DIGITS active-low digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_display_scan
    import seg_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 9,
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    input  logic [3:0]                     SW,
    input  logic                           hex_mode,
    output logic [6:0]                     SEG,
    output logic [NUM_DIGITS-1:0]          AN,
    output logic                           busy,
    output logic                           valid
);

    localparam int              NIB_W   = 4 * NUM_DIGITS;
    localparam int              PRE_W   = $clog2(SCAN_DIV);
    localparam int              IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam longint unsigned MAX_DEC = dec_max(NUM_DIGITS);

    conv_state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]        sel_value;
    logic                         sel_ovf;
    logic                         hex_q;
    logic                         ovf_q;
    logic [NIB_W-1:0]             raw_q;
    logic                         conv_start;
    logic                         conv_done;
    logic [NIB_W-1:0]             conv_bcd;
    logic [NIB_W-1:0]             digits;
    logic [3:0]                   nib;
    logic                         seen_nz;
    logic [NUM_DIGITS-1:0][6:0]   codes;
    logic [NUM_DIGITS-1:0][6:0]   seg_buf_q;
    logic                         valid_q;
    logic [PRE_W-1:0]             presc_q;
    logic [IDX_W-1:0]             idx_q;
    logic [6:0]                   seg_q;
    logic [NUM_DIGITS-1:0]        an_q;

    // Register select: 1..NUM_REGS picks a register, anything else reads 0
    always_comb begin
        sel_value = '0;
        for (int k = 1; k <= NUM_REGS; k++) begin
            if (SW == 4'(k)) begin
                sel_value = reg_data[k*DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    assign sel_ovf = (64'(sel_value) > MAX_DEC);

    // Conversion state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conversion next-state and control strobes
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_LOAD;
            ST_LOAD: begin
                conv_start = 1'b1;
                state_d    = hex_mode ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: if (conv_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    bin2bcd_seq #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk_i   (clock),
        .rst_i   (reset),
        .start_i (conv_start),
        .data_i  (sel_value),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // Sample mode, overflow and raw hex nibbles at LOAD
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_q <= 1'b0;
            ovf_q <= 1'b0;
            raw_q <= '0;
        end else if (state_q == ST_LOAD) begin
            hex_q <= hex_mode;
            ovf_q <= sel_ovf && !hex_mode;
            raw_q <= NIB_W'(sel_value);
        end
    end

    // Segment codes with overflow dashes and leading-zero blanking
    always_comb begin
        digits  = hex_q ? raw_q : conv_bcd;
        seen_nz = 1'b0;
        nib     = '0;
        codes   = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = digits[4*i +: 4];
            if (nib != 4'd0) begin
                seen_nz = 1'b1;
            end
            if (ovf_q) begin
                codes[i] = SEG_DASH;
            end else if (!seen_nz && (i != 0)) begin
                codes[i] = SEG_BLANK;
            end else begin
                codes[i] = SEG_DIGIT[nib];
            end
        end
    end

    // Whole-buffer write in DONE so the display never shows a partial result
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_buf_q <= '1;
            valid_q   <= 1'b0;
        end else if (state_q == ST_DONE) begin
            seg_buf_q <= codes;
            valid_q   <= 1'b1;
        end
    end

    // Prescaler and digit index for the scan
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_q <= '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Registered SEG/AN pair, updated together from the current index
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            seg_q <= seg_buf_q[idx_q];
            an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        end
    end

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign busy  = (state_q != ST_IDLE);
    assign valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_display_scan
//  Description : Directed self-checking bench for seg_display_scan
//                (DATA_WIDTH=16, NUM_REGS=9, NUM_DIGITS=4, SCAN_DIV=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_display_scan;

    localparam int DW = 16;
    localparam int NR = 9;
    localparam int ND = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SX = 7'b1111111;

    logic              clock;
    logic              reset;
    logic [NR*DW-1:0]  reg_data;
    logic [3:0]        SW;
    logic              hex_mode;
    logic [6:0]        SEG;
    logic [ND-1:0]     AN;
    logic              busy;
    logic              valid;

    int checks;
    int errors;

    seg_display_scan #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .NUM_DIGITS (ND),
        .SCAN_DIV   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .reg_data (reg_data),
        .SW       (SW),
        .hex_mode (hex_mode),
        .SEG      (SEG),
        .AN       (AN),
        .busy     (busy),
        .valid    (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_reg(input int k, input logic [DW-1:0] v);
        reg_data[k*DW-1 -: DW] = v;
    endtask

    // Wait for busy to move to lvl; bounded
    task automatic wait_busy(input logic lvl, input string tag);
        logic prev;
        int   n;
        logic hit;
        prev = busy;
        n    = 0;
        hit  = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clock);
            n++;
            if (busy == lvl && prev != lvl) hit = 1'b1;
            prev = busy;
        end
        if (!hit) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Observe one full scan and compare each digit; exp = {d3,d2,d1,d0}
    task automatic scan(input string tag, input logic [27:0] exp);
        logic [7:0] seen [ND];
        int         bad;
        bad = 0;
        for (int i = 0; i < ND; i++) seen[i] = 8'hFF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            if ($countones(~AN) == 1) begin
                for (int i = 0; i < ND; i++) begin
                    if (!AN[i]) seen[i] = {1'b0, SEG};
                end
            end else begin
                bad++;
            end
        end
        chk({tag, "_an_onehot"}, 32'(bad), 32'd0);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s_d%0d", tag, i), 32'(seen[i]), 32'({1'b0, exp[7*i +: 7]}));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        reg_data = '0;
        SW       = 4'd2;
        hex_mode = 1'b0;
        set_reg(2, 16'd1234);

        // Reset held three cycles
        tick(3);
        chk("rst_seg",   32'(SEG),   32'h7F);
        chk("rst_an",    32'(AN),    32'hF);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);

        // First cycle after release: digit 0 enabled, still blank; FSM in LOAD
        reset = 1'b0;
        tick(1);
        chk("first_an",   32'(AN),   32'hE);
        chk("first_seg",  32'(SEG),  32'h7F);
        chk("first_busy", 32'(busy), 32'd1);

        // valid rises after 19 cycles
        tick(17);
        chk("lat_valid18", 32'(valid), 32'd0);
        tick(1);
        chk("lat_valid19", 32'(valid), 32'd1);
        scan("dec1234", {S1, S2, S3, S4});

        // Hex mode
        set_reg(5, 16'hBEEF);
        SW       = 4'd5;
        hex_mode = 1'b1;
        tick(40);
        scan("hexBEEF", {SB, SE, SE, SF});

        // Decimal overflow
        hex_mode = 1'b0;
        set_reg(1, 16'd10000);
        SW = 4'd1;
        tick(40);
        scan("ovf10000", {SD, SD, SD, SD});

        // Leading-zero blanking
        set_reg(1, 16'd7);
        tick(40);
        scan("dec7", {SX, SX, SX, S7});

        // Out-of-range select reads zero
        SW = 4'd12;
        tick(40);
        scan("sw12", {SX, SX, SX, S0});

        // Input change mid-SHIFT only takes effect on the next LOAD
        SW = 4'd2;
        set_reg(2, 16'd1234);
        wait_busy(1'b1, "mid_load");
        tick(3);
        set_reg(2, 16'd9999);
        wait_busy(1'b0, "mid_done1");
        scan("mid_old", {S1, S2, S3, S4});
        wait_busy(1'b0, "mid_done2");
        scan("mid_new", {S9, S9, S9, S9});

        // Reset at SHIFT step 8
        wait_busy(1'b1, "rs_load");
        tick(8);
        chk("rs_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("rs_seg",   32'(SEG),   32'h7F);
        chk("rs_an",    32'(AN),    32'hF);
        chk("rs_valid", 32'(valid), 32'd0);
        chk("rs_busy",  32'(busy),  32'd0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_scan.md
# seg_display_scan

Parametrised multi-digit seven-segment display controller for the board I/O layer. It selects one of `NUM_REGS` CPU register values by switch input and converts the selected value to decimal (sequential double-dabble) or hex. It shows the result across `NUM_DIGITS` time-multiplexed digits, with leading-zero blanking and overflow indication. It supersedes the single-digit, 0–9-only switch-to-segment decoder.

## Interface
Parameters:
- `DATA_WIDTH`, 16: width of each register value, 4..32.
- `NUM_REGS`, 9: number of selectable registers, 1..15.
- `NUM_DIGITS`, 4: physical digits, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥2.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `reg_data`  in  `NUM_REGS*DATA_WIDTH`: packed values. Register k (1-based) is at bits [k*DATA_WIDTH-1 : (k-1)*DATA_WIDTH].
- `SW`  in  4: register select. Values 1..NUM_REGS select that register; any other value selects constant 0.
- `hex_mode`  in  1: 1 shows hexadecimal, 0 shows decimal; sampled with the data.
- `SEG`  out  7: active-low segments {g,f,e,d,c,b,a}.
- `AN`  out  `NUM_DIGITS`: active-low digit enables; bit 0 is the rightmost digit.
- `busy`  out  1: conversion in progress.
- `valid`  out  1: display buffer holds at least one completed conversion.

## Operation
- Conversion FSM with states IDLE, LOAD, SHIFT and DONE. It runs continuously:
  - IDLE→LOAD unconditionally.
  - LOAD samples the selected value and `hex_mode`, clears the BCD accumulator, and sets the shift count to DATA_WIDTH.
  - SHIFT does one double-dabble step per cycle: add 3 to each BCD nibble ≥5, then shift left by 1 with the data MSB entering. After DATA_WIDTH steps it goes to DONE.
  - DONE writes the display buffer atomically, sets `valid`, then returns to IDLE.
- In hex mode SHIFT is skipped and LOAD goes to DONE. The buffer receives the low NUM_DIGITS nibbles.
- Overflow applies to decimal mode only. If the sampled value > 10^NUM_DIGITS−1 (flag computed at LOAD), every digit shows dash `0111111`.
- Leading-zero blanking: digits above the most significant non-zero digit show blank `1111111`. Digit 0 is never blanked, so a value of 0 shows "0". Hex mode applies the same blanking.
- Encodings:
  - 0–9 use the existing table: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - A–F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Scanner:
  - The prescaler counts 0..SCAN_DIV−1. On wrap, the digit index advances modulo NUM_DIGITS.
  - `AN` has exactly one bit low, equal to the index. `SEG` shows that digit's encoding from the buffer.
- Input changes during SHIFT have no effect until the next LOAD. The buffer never shows a partially converted value.

## Timing
- Reset values: `SEG`=1111111, `AN`=all ones, `busy`=0, `valid`=0. Also: buffer blank, FSM IDLE, prescaler 0, digit index 0.
- First `AN` low on the cycle after reset deasserts: digit 0 shows blank until `valid`.
- Decimal latency is DATA_WIDTH+3 cycles from the first IDLE to buffer update: IDLE, LOAD, DATA_WIDTH×SHIFT, DONE. Hex latency is 3 cycles.
- `busy`=1 in LOAD, SHIFT and DONE.
- `SEG` and `AN` are registered and change in the same cycle, one cycle after the index update; no mixed-digit cycle.
- Buffer update is visible on `SEG` on the next registered output cycle. The scan position is not disturbed.
- Reset asserted mid-SHIFT: on the next edge, all state returns to the reset values above. No partial buffer write.

## Structure
- Shared package `seg_pkg`:
  - segment constants `SEG_DIGIT[0:15]`, `SEG_DASH`, `SEG_BLANK`;
  - FSM state typedef `conv_state_t`.
- Sub-module `bin2bcd_seq`: the sequential double-dabble (start/done handshake, parametrised DATA_WIDTH and NUM_DIGITS).
- The top level holds the select mux, overflow compare, buffer, blanking logic and scanner.

## Test plan
Configuration unless stated: DATA_WIDTH=16, NUM_DIGITS=4, SCAN_DIV=4.
- Reset held 3 cycles → `SEG`=1111111, `AN`=1111, `valid`=0, `busy`=0.
- Reg2=1234, SW=2, decimal → `valid` rises after 19 cycles. Scan shows:
  - AN=1110 with SEG=0011001;
  - AN=1101 with 0110000;
  - AN=1011 with 0100100;
  - AN=0111 with 1111001.
- Reg5=0xBEEF, SW=5, hex_mode=1 → digits 0..3 show 0001110, 0000110, 0000110, 0000011.
- Reg1=10000, SW=1, decimal → all four digits show 0111111. Reg1=7 → digit 0 shows 1111000 and digits 1–3 show 1111111.
- SW=12 (out of range) → digit 0 shows 1000000 and the rest are blank. Reset at SHIFT step 8 → outputs equal reset values on the next edge, `valid`=0.
- Reg2 changes 1234→9999 during SHIFT → the buffer shows 1234 after that DONE and 9999 only after the following conversion.
